// File: rtl/mult_vector_pingpong_if.sv
// Handshake bundle for mult_vector_pingpong.
// The slave modport is the bank itself; the master modport is the producer/consumer side.
//   wr_valid/wr_ready/wr_data : write beat channel (one vector of LANES x DATA_W)
//   rd_valid/rd_ready/rd_data : read beat channel, zero read latency
//   rd_bank/rd_idx            : location of the vector currently presented on rd_data
//   full_cnt                  : number of full banks (0..2)
interface mult_vector_pingpong_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                    wr_valid;
  logic                    wr_ready;
  logic [LANES*DATA_W-1:0] wr_data;
  logic                    rd_valid;
  logic                    rd_ready;
  logic [LANES*DATA_W-1:0] rd_data;
  logic                    rd_bank;
  logic [AW-1:0]           rd_idx;
  logic [1:0]              full_cnt;

  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_bank, rd_idx, full_cnt
  );

  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_bank, rd_idx, full_cnt
  );
endinterface

// File: rtl/mult_vector_pingpong.sv
// Double-buffered (ping-pong) vector bank between the vector decode/write-back path and
// the multiply lanes. The writer fills one bank with DEPTH vectors while the consumer
// drains the other; a bank becomes readable once completely written and writable again
// once completely read.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset; clears pointers, full flags and storage
//   flush  : (only when MVB_FLUSH_EN is defined) discards the partial fill of the write bank
//   bus    : mult_vector_pingpong_if.slave (write channel, read channel, status)
// Optional feature macro: MVB_FLUSH_EN (default build leaves it undefined, no flush port).
module mult_vector_pingpong #(
  parameter int DATA_W = 32,
  parameter int LANES  = 4,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
`ifdef MVB_FLUSH_EN
  input  logic                   flush,
`endif
  mult_vector_pingpong_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int W  = LANES * DATA_W;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  logic [W-1:0]  mem_q [2][DEPTH];
  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_idx_q,  wr_idx_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] rd_idx_q,  rd_idx_d;
  logic [1:0]    full_q,    full_d;

  logic flush_w;
  logic wr_fire;
  logic rd_fire;

`ifdef MVB_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // Flush blocks the write channel for that cycle so the discard cannot race a new beat.
  assign bus.wr_ready = ~full_q[wr_bank_q] & ~flush_w;
  assign bus.rd_valid = full_q[rd_bank_q];
  assign bus.rd_data  = mem_q[rd_bank_q][rd_idx_q];
  assign bus.rd_bank  = rd_bank_q;
  assign bus.rd_idx   = rd_idx_q;
  assign bus.full_cnt = {1'b0, full_q[0]} + {1'b0, full_q[1]};

  assign wr_fire = bus.wr_valid & bus.wr_ready;
  assign rd_fire = bus.rd_valid & bus.rd_ready;

  // Write completion only touches a non-full bank and read completion only a full one,
  // so both updates of full_d below always land on different bits.
  always_comb begin
    wr_bank_d = wr_bank_q;
    wr_idx_d  = wr_idx_q;
    rd_bank_d = rd_bank_q;
    rd_idx_d  = rd_idx_q;
    full_d    = full_q;

    if (flush_w) begin
      wr_idx_d = '0;
    end

    if (wr_fire) begin
      if (wr_idx_q == LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + AW'(1);
      end
    end

    if (rd_fire) begin
      if (rd_idx_q == LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_idx_d          = '0;
      end else begin
        rd_idx_d = rd_idx_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[b][i] <= '0;
        end
      end
      wr_bank_q <= 1'b0;
      wr_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      full_q    <= 2'b00;
    end else begin
      if (wr_fire) begin
        mem_q[wr_bank_q][wr_idx_q] <= bus.wr_data;
      end
      wr_bank_q <= wr_bank_d;
      wr_idx_q  <= wr_idx_d;
      rd_bank_q <= rd_bank_d;
      rd_idx_q  <= rd_idx_d;
      full_q    <= full_d;
    end
  end
endmodule

// File: tb/tb_mult_vector_pingpong.sv
module tb_mult_vector_pingpong;
  localparam int DATA_W = 32;
  localparam int LANES  = 4;
  localparam int DEPTH  = 4;
  localparam int W      = LANES * DATA_W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic fl    = 1'b0;
  logic fl1   = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mult_vector_pingpong_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();
  mult_vector_pingpong_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(1))     bus1 ();

  mult_vector_pingpong #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MVB_FLUSH_EN
    .flush (fl),
`endif
    .bus   (bus)
  );

  mult_vector_pingpong #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
`ifdef MVB_FLUSH_EN
    .flush (fl1),
`endif
    .bus   (bus1)
  );

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: vectors of full banks are a FIFO; a bank is drained in order.
  logic [W-1:0] m_full[$];   // unread vectors of full banks, oldest first
  logic [W-1:0] m_part[$];   // vectors of the bank being filled
  int m_rpos  = 0;           // vectors already read from the oldest full bank
  int m_rdone = 0;           // banks completely drained since reset
  int m_c;
  bit m_wf, m_rf;

  function automatic int m_cnt();
    return (m_full.size() + m_rpos) / DEPTH;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_full.delete();
      m_part.delete();
      m_rpos  = 0;
      m_rdone = 0;
    end else begin
      m_c  = m_cnt();
      m_rf = bus.rd_ready && (m_c > 0);
      m_wf = bus.wr_valid && (m_c < 2) && !fl;
      if (fl) m_part.delete();
      if (m_rf) begin
        void'(m_full.pop_front());
        m_rpos++;
        if (m_rpos == DEPTH) begin
          m_rpos = 0;
          m_rdone++;
        end
      end
      if (m_wf) begin
        m_part.push_back(bus.wr_data);
        if (m_part.size() == DEPTH) begin
          foreach (m_part[i]) m_full.push_back(m_part[i]);
          m_part.delete();
        end
      end
    end
  end

  int cc;
  always @(negedge clk) begin
    if (rst_n) begin
      cc = m_cnt();
      check("wr_ready", W'(bus.wr_ready), W'((cc < 2) && !fl));
      check("rd_valid", W'(bus.rd_valid), W'(cc > 0));
      check("full_cnt", W'(bus.full_cnt), W'(cc));
      check("rd_bank",  W'(bus.rd_bank),  W'(m_rdone % 2));
      check("rd_idx",   W'(bus.rd_idx),   W'(m_rpos));
      if (cc > 0) check("rd_data", bus.rd_data, m_full[0]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [W-1:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    cyc();
    bus.wr_valid = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] rnd_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [W-1:0] ramp(input int a);
    return {32'(a + 3), 32'(a + 2), 32'(a + 1), 32'(a)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  logic [W-1:0] b9;
  logic [W-1:0] pv [4];

  initial begin
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    bus1.wr_valid = 1'b0;
    bus1.wr_data  = '0;
    bus1.rd_ready = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // reset in the middle of a fill
    put(rnd_vec());
    put(rnd_vec());
    do_reset();
    check("rst wr_ready", W'(bus.wr_ready), W'(1));
    check("rst rd_valid", W'(bus.rd_valid), W'(0));
    check("rst full_cnt", W'(bus.full_cnt), W'(0));
    check("rst rd_data",  bus.rd_data, '0);

    // fill one bank, then drain it
    for (int i = 1; i <= 4; i++) put({4{32'(i)}});
    check("fill rd_valid", W'(bus.rd_valid), W'(1));
    check("fill rd_bank",  W'(bus.rd_bank),  W'(0));
    check("fill rd_idx",   W'(bus.rd_idx),   W'(0));
    check("fill full_cnt", W'(bus.full_cnt), W'(1));
    bus.rd_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("drain rd_data", bus.rd_data, {4{32'(i)}});
      cyc();
    end
    bus.rd_ready = 1'b0;
    check("drain rd_valid", W'(bus.rd_valid), W'(0));

    // back-pressure with both banks full
    do_reset();
    for (int i = 0; i < 8; i++) put(rnd_vec());
    check("bp full_cnt", W'(bus.full_cnt), W'(2));
    check("bp wr_ready", W'(bus.wr_ready), W'(0));
    b9 = rnd_vec();
    bus.wr_valid = 1'b1;
    bus.wr_data  = b9;
    cyc();
    cyc();
    check("bp held", W'(bus.wr_ready), W'(0));
    bus.rd_ready = 1'b1;
    repeat (4) cyc();
    bus.rd_ready = 1'b0;
    check("bp wr_ready rise", W'(bus.wr_ready), W'(1));
    check("bp full_cnt 1",    W'(bus.full_cnt), W'(1));
    check("bp rd_bank 1",     W'(bus.rd_bank),  W'(1));
    cyc();
    bus.wr_valid = 1'b0;
    for (int i = 0; i < 3; i++) put(rnd_vec());
    check("bp refill full_cnt", W'(bus.full_cnt), W'(2));
    bus.rd_ready = 1'b1;
    repeat (4) cyc();
    bus.rd_ready = 1'b0;
    check("bp beat9 bank", W'(bus.rd_bank), W'(0));
    check("bp beat9 data", bus.rd_data, b9);

    // final write of bank 1 coincides with final read of bank 0
    do_reset();
    for (int i = 0; i < 4; i++) put(rnd_vec());
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) put(rnd_vec());
    bus.rd_ready = 1'b0;
    check("sim full_cnt", W'(bus.full_cnt), W'(1));
    check("sim rd_bank",  W'(bus.rd_bank),  W'(1));
    check("sim rd_idx",   W'(bus.rd_idx),   W'(0));
    check("sim wr_ready", W'(bus.wr_ready), W'(1));
    check("sim rd_valid", W'(bus.rd_valid), W'(1));

`ifdef MVB_FLUSH_EN
    // flush discards the partial fill and blocks the concurrent beat
    do_reset();
    put(rnd_vec());
    put(rnd_vec());
    bus.wr_valid = 1'b1;
    bus.wr_data  = rnd_vec();
    fl = 1'b1;
    #1;
    check("flush wr_ready", W'(bus.wr_ready), W'(0));
    cyc();
    fl = 1'b0;
    bus.wr_valid = 1'b0;
    check("flush full_cnt 0", W'(bus.full_cnt), W'(0));
    for (int i = 0; i < 4; i++) begin
      pv[i] = rnd_vec();
      put(pv[i]);
    end
    check("flush full_cnt 1", W'(bus.full_cnt), W'(1));
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("flush data", bus.rd_data, pv[i]);
      cyc();
    end
    bus.rd_ready = 1'b0;
`endif

    // randomized traffic against the model
    do_reset();
    for (int seg = 0; seg < 5; seg++) begin
      int pw, pr;
      pw = 20 + 20 * seg;
      pr = 100 - 20 * seg;
      for (int t = 0; t < 300; t++) begin
        bus.wr_valid = ($urandom_range(0, 99) < pw);
        bus.wr_data  = rnd_vec();
        bus.rd_ready = ($urandom_range(0, 99) < pr);
`ifdef MVB_FLUSH_EN
        fl = ($urandom_range(0, 99) < 3);
`endif
        cyc();
      end
    end
    bus.wr_valid = 1'b0;
    bus.rd_ready = 1'b0;
    fl = 1'b0;

    // DEPTH=1 streaming: one vector per clock after a single fill cycle
    do_reset();
    bus1.rd_ready = 1'b1;
    bus1.wr_valid = 1'b1;
    bus1.wr_data  = ramp(1);
    check("stream first rd_valid", W'(bus1.rd_valid), W'(0));
    cyc();
    for (int i = 1; i <= 100; i++) begin
      check("stream rd_valid", W'(bus1.rd_valid), W'(1));
      check("stream wr_ready", W'(bus1.wr_ready), W'(1));
      check("stream rd_data",  bus1.rd_data, ramp(i));
      bus1.wr_data = ramp(i + 1);
      cyc();
    end
    bus1.wr_valid = 1'b0;
    bus1.rd_ready = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
